// File: rtl/cache_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cache_wb_buffer
// Description : Write-back (victim) buffer between the L1 cache memory port
//               and main memory. Absorbs dirty-line evictions in a circular
//               FIFO, drains them in the background and forwards pending
//               lines to cache line-fill reads.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a,
    input  logic              read,
    input  logic              write,
    input  logic [LINE_W-1:0] wd,
    output logic [LINE_W-1:0] rd,
    output logic              rd_valid,
    output logic              ready,
    output logic              empty,
    output logic [ADDR_W-1:0] mm_a,
    output logic              mm_read,
    output logic              mm_write,
    output logic [LINE_W-1:0] mm_wd,
    input  logic [LINE_W-1:0] mm_rd,
    input  logic              mm_rd_valid,
    input  logic              mm_ready
);

    localparam int LA_W  = ADDR_W - 5;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DR_WAIT = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RD_HIT  = 3'd5
    } state_t;

    state_t             state;
    state_t             next_state;

    // Entry storage: valid bits are reset, address/data arrays are not.
    logic [DEPTH-1:0]   valid;
    logic [LA_W-1:0]    line_mem [DEPTH];
    logic [LINE_W-1:0]  data_mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    // Held off until the first clock after reset so ready stays low in reset.
    logic               active;
    logic [LA_W-1:0]    req_line;

    logic [LA_W-1:0]    a_line;
    logic               hit;
    logic [PTR_W-1:0]   hit_idx;
    logic               accept;
    logic               do_alloc;
    logic               do_merge;
    logic               do_drain;
    logic               do_hit;
    logic               do_mm_read;
    logic               do_resp;
    logic               unused_bits;

    assign a_line      = a[ADDR_W-1:5];
    assign unused_bits = ^a[4:0];

    assign ready  = active && (state == ST_IDLE || state == ST_DR_WAIT) && (count < FULL_COUNT);
    assign empty  = (count == '0) && (state == ST_IDLE);
    assign accept = ready && (read || write);

    // Associative lookup of the request line against all valid entries.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (line_mem[i] == a_line)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath strobes; a read wins when read and write collide.
    always_comb begin
        next_state = state;
        do_alloc   = 1'b0;
        do_merge   = 1'b0;
        do_drain   = 1'b0;
        do_hit     = 1'b0;
        do_mm_read = 1'b0;
        do_resp    = 1'b0;
        case (state)
            ST_IDLE, ST_DR_WAIT: begin
                if (state == ST_DR_WAIT && mm_ready) begin
                    next_state = ST_IDLE;
                end
                if (accept) begin
                    if (read) begin
                        if (hit) begin
                            do_hit     = 1'b1;
                            next_state = ST_RD_HIT;
                        end else begin
                            next_state = ST_RD_REQ;
                        end
                    end else if (hit) begin
                        do_merge = 1'b1;
                    end else begin
                        do_alloc = 1'b1;
                    end
                end else if (state == ST_IDLE && count != '0 && mm_ready) begin
                    do_drain   = 1'b1;
                    next_state = ST_DR_WAIT;
                end
            end
            ST_RD_REQ: begin
                if (mm_ready) begin
                    do_mm_read = 1'b1;
                    next_state = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mm_rd_valid) begin
                    do_resp    = 1'b1;
                    next_state = ST_RD_RESP;
                end
            end
            ST_RD_RESP, ST_RD_HIT: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: allocate at tail, dequeue at head, never both at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            active   <= 1'b0;
            req_line <= '0;
        end else begin
            active <= 1'b1;
            if (do_alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
                count       <= count + 1'b1;
            end
            if (do_drain) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
                count       <= count - 1'b1;
            end
            if (accept && read) begin
                req_line <= a_line;
            end
        end
    end

    // Entry address/data storage; a merge rewrites data in place.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            line_mem[tail] <= a_line;
            data_mem[tail] <= wd;
        end
        if (do_merge) begin
            data_mem[hit_idx] <= wd;
        end
    end

    // Registered cache-side and memory-side outputs; data buses hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd       <= '0;
            rd_valid <= 1'b0;
            mm_a     <= '0;
            mm_read  <= 1'b0;
            mm_write <= 1'b0;
            mm_wd    <= '0;
        end else begin
            rd_valid <= do_hit || do_resp;
            mm_read  <= do_mm_read;
            mm_write <= do_drain;
            if (do_hit) begin
                rd <= data_mem[hit_idx];
            end else if (do_resp) begin
                rd <= mm_rd;
            end
            if (do_drain) begin
                mm_a  <= {line_mem[head], 5'b0};
                mm_wd <= data_mem[head];
            end else if (do_mm_read) begin
                mm_a  <= {req_line, 5'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_wb_buffer
// Description : Directed self-checking bench for cache_wb_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_wb_buffer;

    logic         clk;
    logic         reset;
    logic [31:0]  a;
    logic         read;
    logic         write;
    logic [255:0] wd;
    logic [255:0] rd;
    logic         rd_valid;
    logic         ready;
    logic         empty;
    logic [31:0]  mm_a;
    logic         mm_read;
    logic         mm_write;
    logic [255:0] mm_wd;
    logic [255:0] mm_rd;
    logic         mm_rd_valid;
    logic         mm_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int drains;
    int found;

    cache_wb_buffer #(
        .DEPTH  (4),
        .LINE_W (256),
        .ADDR_W (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .read        (read),
        .write       (write),
        .wd          (wd),
        .rd          (rd),
        .rd_valid    (rd_valid),
        .ready       (ready),
        .empty       (empty),
        .mm_a        (mm_a),
        .mm_read     (mm_read),
        .mm_write    (mm_write),
        .mm_wd       (mm_wd),
        .mm_rd       (mm_rd),
        .mm_rd_valid (mm_rd_valid),
        .mm_ready    (mm_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The bench itself must never drive read and write together.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(read && write)) else begin
                n_fail++;
                $error("FAIL protocol: read and write asserted together");
            end
        end
    end

    function automatic logic [255:0] dat(input int k);
        logic [31:0] w;
        w = 32'(k) * 32'h0101_0101 + 32'h1357_9BDF;
        dat = {w, ~w, w ^ 32'hFFFF_0000, w + 32'd1, w - 32'd1,
               {w[15:0], w[31:16]}, w ^ 32'h0F0F_0F0F, ~w + 32'd7};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; read = 1'b0; write = 1'b0; a = '0; wd = '0;
        mm_rd = '0; mm_rd_valid = 1'b0; mm_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        // Reset values
        check("rst_ready",    ready,    0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_mm_read",  mm_read,  0);
        check("rst_mm_write", mm_write, 0);
        check("rst_rd",       rd,       0);
        check("rst_mm_a",     mm_a,     0);
        check("rst_mm_wd",    mm_wd,    0);
        check("rst_empty",    empty,    1);
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        check("post_rst_ready", ready, 1);
        check("post_rst_empty", empty, 1);

        // Hit forwarding
        write = 1'b1; a = 32'h0000_1000; wd = dat(1);
        cyc();
        write = 1'b0;
        check("wr_not_empty", empty, 0);
        read = 1'b1; a = 32'h0000_1008;
        cyc();
        read = 1'b0;
        check("hit_rd_valid", rd_valid, 1);
        check("hit_rd",       rd,       dat(1));
        check("hit_no_mmrd",  mm_read,  0);
        cyc();
        check("hit_pulse_end", rd_valid, 0);
        check("hit_rd_hold",   rd,       dat(1));
        check("hit_no_mmrd2",  mm_read,  0);
        mm_ready = 1'b1;
        cyc();
        check("hit_drain_wr", mm_write, 1);
        check("hit_drain_a",  mm_a,     32'h0000_1000);
        check("hit_drain_wd", mm_wd,    dat(1));
        cyc();
        check("hit_drain_end", mm_write, 0);
        check("hit_mm_a_hold", mm_a,     32'h0000_1000);
        check("hit_empty",     empty,    1);
        mm_ready = 1'b0;

        // Full / FIFO order
        for (int k = 1; k <= 4; k++) begin
            write = 1'b1; a = 32'(k) * 32'h1000; wd = dat(k + 10);
            cyc();
        end
        check("full_ready", ready, 0);
        a = 32'h0000_6000; wd = dat(20);
        cyc();
        check("full_stall_rdy1", ready,    0);
        check("full_stall_mw1",  mm_write, 0);
        cyc();
        check("full_stall_rdy2", ready,    0);
        write = 1'b0;
        mm_ready = 1'b1;
        drains = 0;
        for (int c = 0; c < 14; c++) begin
            cyc();
            if (mm_write) begin
                if (drains < 4) begin
                    check("fifo_mm_a",  mm_a,  32'(drains + 1) * 32'h1000);
                    check("fifo_mm_wd", mm_wd, dat(drains + 11));
                end
                if (drains == 0) check("fifo_ready_after_drain", ready, 1);
                drains++;
            end
        end
        check("fifo_drain_count", drains, 4);
        check("fifo_empty",       empty,  1);
        mm_ready = 1'b0;

        // Merge
        write = 1'b1; a = 32'h0000_5000; wd = dat(31);
        cyc();
        a = 32'h0000_5010; wd = dat(32);
        cyc();
        write = 1'b0;
        mm_ready = 1'b1;
        drains = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (mm_write) begin
                check("merge_mm_a",  mm_a,  32'h0000_5000);
                check("merge_mm_wd", mm_wd, dat(32));
                drains++;
            end
        end
        check("merge_drain_count", drains, 1);
        check("merge_empty",       empty,  1);

        // Read miss with a memory latency of 4
        read = 1'b1; a = 32'h0000_8000;
        cyc();
        read = 1'b0;
        check("miss_ready_req", ready,   0);
        check("miss_no_mmrd",   mm_read, 0);
        cyc();
        check("miss_mm_read", mm_read, 1);
        check("miss_mm_a",    mm_a,    32'h0000_8000);
        cyc();
        check("miss_mmrd_pulse", mm_read, 0);
        check("miss_ready_wait", ready,   0);
        cyc(); cyc();
        mm_rd_valid = 1'b1; mm_rd = dat(40);
        check("miss_no_early_valid", rd_valid, 0);
        cyc();
        mm_rd_valid = 1'b0;
        check("miss_rd_valid", rd_valid, 1);
        check("miss_rd",       rd,       dat(40));
        check("miss_ready_resp", ready,  0);
        cyc();
        check("miss_valid_end", rd_valid, 0);
        check("miss_rd_hold",   rd,       dat(40));
        check("miss_ready_end", ready,    1);

        // Priority: read miss ahead of a pending drain
        mm_ready = 1'b0;
        write = 1'b1; a = 32'h0000_9000; wd = dat(50);
        cyc();
        write = 1'b0;
        mm_ready = 1'b1; read = 1'b1; a = 32'h0000_A000;
        cyc();
        read = 1'b0;
        check("prio_no_drain", mm_write, 0);
        cyc();
        check("prio_mm_read",  mm_read,  1);
        check("prio_mm_a",     mm_a,     32'h0000_A000);
        check("prio_no_drain2", mm_write, 0);
        cyc();
        check("prio_no_drain3", mm_write, 0);
        cyc();
        mm_rd_valid = 1'b1; mm_rd = dat(60);
        cyc();
        mm_rd_valid = 1'b0;
        check("prio_rd_valid", rd_valid, 1);
        check("prio_rd",       rd,       dat(60));
        found = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (mm_write && found == 0) begin
                check("prio_drain_a",  mm_a,  32'h0000_9000);
                check("prio_drain_wd", mm_wd, dat(50));
                found = 1;
            end
        end
        check("prio_drain_seen", found, 1);
        check("prio_empty",      empty, 1);

        // Reset during a drain with two entries still pending
        mm_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            write = 1'b1; a = 32'h0000_B000 + 32'(k) * 32'h1000; wd = dat(70 + k);
            cyc();
        end
        write = 1'b0;
        mm_ready = 1'b1;
        cyc();
        check("rstd_mm_write", mm_write, 1);
        check("rstd_mm_a",     mm_a,     32'h0000_B000);
        check("rstd_not_empty", empty,   0);
        #2 reset = 1'b1;
        #1;
        check("rstd_ready",    ready,    0);
        check("rstd_rd_valid", rd_valid, 0);
        check("rstd_mm_read",  mm_read,  0);
        check("rstd_mm_wr",    mm_write, 0);
        check("rstd_rd",       rd,       0);
        check("rstd_mm_a0",    mm_a,     0);
        check("rstd_mm_wd",    mm_wd,    0);
        check("rstd_empty",    empty,    1);
        cyc();
        reset = 1'b0;
        drains = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (mm_write) drains++;
        end
        check("rstd_no_drain", drains, 0);
        check("rstd_empty2",   empty,  1);
        check("rstd_ready2",   ready,  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_wb_buffer.md
Name: cache_wb_buffer

Overview:
- Write-back (victim) buffer between the L1 cache's main-memory port and mainmemory.
- Absorbs dirty-line evictions from the cache and drains them to mainmemory in the background.
- Services cache line-fill reads, forwarding data from the buffer when the line is still pending.
- Uses the same 256b line interface as the cache on both sides, so it drops in between cache and mainmemory without changes to either.

Parameters:
DEPTH, 4, number of line entries (power of 2, >=2)
LINE_W, 256, line data width in bits
ADDR_W, 32, byte address width; the line address is a[ADDR_W-1:5]

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
a  input  ADDR_W  cache request address; a[4:0] ignored
read  input  1  line-fill read request from cache
write  input  1  eviction write request from cache
wd  input  LINE_W  eviction line data
rd  output  LINE_W  fill line data to cache
rd_valid  output  1  rd valid, one-cycle pulse
ready  output  1  buffer can accept a read or write this cycle
empty  output  1  no pending entries and state IDLE
mm_a  output  ADDR_W  mainmemory line address, bits [4:0] = 0
mm_read  output  1  mainmemory read command, one-cycle pulse
mm_write  output  1  mainmemory write command, one-cycle pulse
mm_wd  output  LINE_W  mainmemory write data
mm_rd  input  LINE_W  mainmemory read data
mm_rd_valid  input  1  mm_rd valid
mm_ready  input  1  mainmemory can accept a command

Behaviour:
- Storage is a circular FIFO of DEPTH entries {valid, line_addr[ADDR_W-6:0], data}, with head/tail pointers that wrap modulo DEPTH. Count width is clog2(DEPTH+1).
- A request is accepted on a rising clk edge when ready=1 and read or write is asserted.
- ready = (state==IDLE or DR_WAIT) and (count<DEPTH). It is a function of registered state only.
- read and write asserted together is a protocol violation. The block treats it as a read and drops the write; the bench asserts this never occurs.
- Accepted write, line address matches a valid entry: overwrite that entry's data in place (merge). No new entry is created and count is unchanged.
- Accepted write, no match: allocate at tail, tail+1, count+1.
- Accepted read, line address matches a valid entry (hit): go to RD_HIT. rd = entry data and rd_valid=1 in the cycle after acceptance, so latency is 1. No mm access.
- Accepted read, miss: go to RD_REQ.
- States:
  - IDLE: accept requests. When no request is presented, count>0 and mm_ready=1, issue a drain: a one-cycle mm_write pulse with mm_a={head addr,5'b0} and mm_wd=head data, then dequeue the head (head+1, count-1) and go to DR_WAIT. Incoming requests take priority over drain.
  - DR_WAIT: minimum 1 cycle. Exit to IDLE when mm_ready=1. Accepts writes and read hits; an accepted read miss goes to RD_REQ.
  - RD_REQ: wait for mm_ready=1, then pulse mm_read for one cycle with mm_a={a line,5'b0}, and go to RD_WAIT.
  - RD_WAIT: on mm_rd_valid, capture mm_rd and go to RD_RESP.
  - RD_RESP: rd=captured data, rd_valid=1 for one cycle, then IDLE.
  - RD_HIT: rd_valid=1 for one cycle, then IDLE.
- No drain is issued in RD_* states, so no read/write ordering hazard exists.
- At most one mm command is outstanding at any time.
- Drain order is strictly FIFO. A merged entry keeps its original position.
- Full (count==DEPTH): ready=0. Draining continues, and ready rises the cycle after the dequeue.
- empty = (count==0) and state==IDLE.
- rd holds its last value when rd_valid=0. mm_a and mm_wd hold their last values when no command is active.
- Reset (async, any state): all entries invalid, head=tail=count=0, state=IDLE.
  - Outputs during reset: ready=0, rd_valid=0, mm_read=0, mm_write=0, rd=0, mm_a=0, mm_wd=0, empty=1.
  - After reset deasserts: ready=1.
  - A reset during an outstanding mm read discards the response, and a pending mm_rd_valid after reset is ignored.
  - Pending evictions are lost on reset.

Test Plan:
- Hit forwarding: with mm_ready=0, write a=0x0000_1000 wd=D1, then read a=0x0000_1008 → rd=D1, rd_valid exactly one cycle after acceptance, mm_read never asserted.
- Full/FIFO: hold mm_ready=0 and write lines 0x1000, 0x2000, 0x3000, 0x4000 → ready=0 after the 4th accept and a 5th write stalls. Raise mm_ready → mm_write sequence 0x1000, 0x2000, 0x3000, 0x4000 with matching data; ready rises after the first drain; empty=1 at the end.
- Merge: with mm_ready=0, write 0x5000 D1 then 0x5010 D2 → count=1. After mm_ready=1, exactly one mm_write: mm_a=0x5000, mm_wd=D2.
- Read miss: read a=0x8000 with an empty buffer and a mainmemory read latency of 4 → one mm_read pulse with mm_a=0x8000, rd_valid one cycle after mm_rd_valid, rd=mm_rd; ready=0 until the response.
- Priority: with one entry pending and mm_ready=1, present a back-to-back read miss → mm_read is issued before the drain mm_write, and the drain follows once the read returns.
- Reset mid-drain: assert reset in DR_WAIT with 2 entries pending → all outputs take reset values immediately, empty=1, and no mm_write occurs after reset release.
